// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID pipeline register and a one-entry skid buffer.
// One outstanding imem request at a time; PCCR redirects, LRCR saves a link address.
module if_stage #(
    parameter int              IW       = 16,
    parameter int              AW       = 8,
    parameter logic [AW-1:0]   RESET_PC = '0,
    parameter logic [3:0]      NOP_OP   = 4'h0
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_rdata,
    input  logic          stall,
    input  logic          PCCR,
    input  logic [AW-1:0] pc_target,
    input  logic          LRCR,
    output logic [3:0]    Oi,
    output logic [IW-1:0] ifid_instr,
    output logic [AW-1:0] ifid_pc,
    output logic          ifid_valid,
    output logic [AW-1:0] lr_out
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t        state, state_n;
    logic [AW-1:0] pc, pc_n;
    logic [IW-1:0] ifid_instr_n;
    logic [AW-1:0] ifid_pc_n;
    logic          ifid_valid_n;
    logic [IW-1:0] skid_instr, skid_instr_n;
    logic [AW-1:0] skid_pc, skid_pc_n;
    logic          skid_valid, skid_valid_n;
    logic [AW-1:0] lr_n;
    logic          ifid_free;

    assign imem_req  = (state == FETCH) && !rst;
    assign imem_addr = pc;
    assign Oi        = ifid_valid ? ifid_instr[IW-1:IW-4] : NOP_OP;
    assign ifid_free = !ifid_valid || !stall;

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        ifid_instr_n = ifid_instr;
        ifid_pc_n    = ifid_pc;
        ifid_valid_n = ifid_valid;
        skid_instr_n = skid_instr;
        skid_pc_n    = skid_pc;
        skid_valid_n = skid_valid;
        lr_n         = lr_out;

        if (PCCR) begin
            // Redirect wins: any ack this cycle is dropped and the skid is discarded.
            pc_n         = pc_target;
            ifid_valid_n = 1'b0;
            skid_valid_n = 1'b0;
            state_n      = FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        pc_n = pc + AW'(1);
                        if (ifid_free) begin
                            ifid_instr_n = imem_rdata;
                            ifid_pc_n    = pc;
                            ifid_valid_n = 1'b1;
                        end else begin
                            skid_instr_n = imem_rdata;
                            skid_pc_n    = pc;
                            skid_valid_n = 1'b1;
                            state_n      = HOLD;
                        end
                    end else if (ifid_valid && !stall) begin
                        ifid_valid_n = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ifid_instr_n = skid_instr;
                        ifid_pc_n    = skid_pc;
                        ifid_valid_n = 1'b1;
                        skid_valid_n = 1'b0;
                        state_n      = FETCH;
                    end
                end
                default: state_n = FETCH;
            endcase
        end

        if (LRCR) begin
            lr_n = ifid_pc + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            ifid_instr <= '0;
            ifid_pc    <= '0;
            ifid_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
            skid_valid <= 1'b0;
            lr_out     <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            ifid_instr <= ifid_instr_n;
            ifid_pc    <= ifid_pc_n;
            ifid_valid <= ifid_valid_n;
            skid_instr <= skid_instr_n;
            skid_pc    <= skid_pc_n;
            skid_valid <= skid_valid_n;
            lr_out     <= lr_n;
        end
    end

endmodule
